// File: rtl/ifu.sv
// Instruction fetch unit: owns the PC and fetches one word at a time.
// Redirects from execute squash any in-flight or held instruction.
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] pc
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    HOLD
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_kill;
  logic [31:0] w_tgt;
  logic        w_unused;

  assign w_tgt    = {redirect_pc[31:2], 2'b00};
  assign w_unused = &{1'b0, redirect_pc[1:0]};

  assign imem_req_valid = (r_state == FETCH);
  assign imem_req_addr  = {r_pc[31:2], 2'b00};
  assign pc             = r_pc;
  assign inst_valid     = (r_state == HOLD);
  assign inst           = (r_state == HOLD) ? r_inst : NOP_INST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BOOT;
      r_pc    <= RESET_PC;
      r_inst  <= NOP_INST;
      r_kill  <= 1'b0;
    end else begin
      unique case (r_state)
        BOOT: begin
          r_state <= FETCH;
        end
        FETCH: begin
          // a redirect racing the handshake leaves the old request in flight
          r_kill <= redirect_valid;
          if (redirect_valid) r_pc <= w_tgt;
          if (imem_req_ready) r_state <= WAIT;
        end
        WAIT: begin
          if (redirect_valid) begin
            r_pc   <= w_tgt;
            r_kill <= 1'b1;
          end
          if (imem_resp_valid) begin
            if (r_kill || redirect_valid) begin
              r_kill  <= 1'b0;
              r_state <= FETCH;
            end else begin
              r_inst  <= imem_resp_data;
              r_state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_tgt;
            r_state <= FETCH;
          end else if (inst_ready) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= FETCH;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios with literal checks,
// then randomized traffic compared every cycle against a flag-based model.
module tb_ifu;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        resp_valid = 1'b0;
  logic [31:0] resp_data = 32'h0;
  logic        redir_v = 1'b0;
  logic [31:0] redir_pc = 32'h0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] pc;

  always #5 clk = ~clk;

  ifu #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(resp_valid),
    .imem_resp_data(resp_data),
    .redirect_valid(redir_v),
    .redirect_pc(redir_pc),
    .inst(inst),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .pc(pc)
  );

  int checks = 0;
  int failures = 0;

  // model: what the fetch unit is doing, as independent flags
  bit          m_booted, m_inflight, m_stale, m_held;
  logic [31:0] m_pc, m_inst;

  // memory responder
  bit          mem_busy, mem_now, spur_en;
  int          mem_cnt, mem_delay;
  logic [31:0] mem_addr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0050_0093;
    return {a[15:0] ^ 16'hbeef, a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_booted = 0; m_inflight = 0; m_stale = 0; m_held = 0;
    m_pc = RPC; m_inst = NOP;
  endtask

  function automatic bit m_req();
    return m_booted && !m_inflight && !m_held;
  endfunction

  task automatic model_step();
    logic [31:0] t;
    t = {redir_pc[31:2], 2'b00};
    if (!rst_n) model_reset();
    else if (!m_booted) m_booted = 1;
    else if (m_held) begin
      if (redir_v) begin m_held = 0; m_pc = t; end
      else if (inst_ready) begin m_held = 0; m_pc = m_pc + 32'd4; end
    end else if (m_inflight) begin
      if (redir_v) begin m_pc = t; m_stale = 1; end
      if (resp_valid) begin
        m_inflight = 0;
        if (m_stale) m_stale = 0;
        else begin m_held = 1; m_inst = resp_data; end
      end
    end else begin
      m_stale = redir_v;
      if (redir_v) m_pc = t;
      if (req_ready) m_inflight = 1;
    end
  endtask

  task automatic compare();
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_req()});
    chk("req_addr", imem_req_addr, {m_pc[31:2], 2'b00});
    chk("pc", pc, m_pc);
    chk("inst_valid", {31'b0, inst_valid}, {31'b0, m_held});
    chk("inst", inst, m_held ? m_inst : NOP);
  endtask

  task automatic tick();
    bit hs, gen;
    logic [31:0] a;
    hs  = m_req() && req_ready && rst_n;
    a   = {m_pc[31:2], 2'b00};
    gen = mem_now;
    @(posedge clk);
    model_step();
    if (gen) mem_busy = 0;
    if (hs) begin
      mem_busy = 1; mem_addr = a; mem_cnt = mem_delay;
    end else if (mem_busy && mem_cnt > 0) mem_cnt--;
    #1;
    compare();
    if (mem_busy && mem_cnt == 0) begin
      resp_valid = 1; resp_data = memf(mem_addr); mem_now = 1;
    end else begin
      mem_now = 0;
      if (spur_en && $urandom_range(0, 7) == 0) begin
        resp_valid = 1; resp_data = $urandom;
      end else resp_valid = 0;
    end
    redir_v = 0;
  endtask

  task automatic redirect(input logic [31:0] t);
    redir_v = 1; redir_pc = t;
  endtask

  initial begin
    model_reset();
    mem_busy = 0; mem_now = 0; spur_en = 0; mem_cnt = 0; mem_delay = 0;
    mem_addr = 0;
    req_ready = 1; inst_ready = 1;
    tick(); tick();
    chk("rst req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst addr", imem_req_addr, RPC);
    chk("rst inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst inst", inst, NOP);
    chk("rst pc", pc, RPC);

    // first fetch with zero-wait memory
    rst_n = 1;
    tick();
    chk("boot req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("boot addr", imem_req_addr, 32'h8000_0000);
    tick(); tick();
    chk("first inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("first inst", inst, 32'h0050_0093);
    chk("first pc", pc, 32'h8000_0000);
    tick();
    chk("next addr", imem_req_addr, 32'h8000_0004);

    // backpressure on both sides
    req_ready = 0; inst_ready = 0;
    redirect(32'h8000_0000);
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall addr", imem_req_addr, 32'h8000_0000);
    end
    req_ready = 1; tick();
    req_ready = 0; tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold inst", inst, 32'h0050_0093);
      chk("hold pc", pc, 32'h8000_0000);
    end
    inst_ready = 1; tick();
    chk("one incr", imem_req_addr, 32'h8000_0004);
    inst_ready = 0;

    // redirect while waiting on a slow response
    mem_delay = 2; req_ready = 1; tick();
    req_ready = 0; redirect(32'h8000_0100); tick();
    tick();
    chk("stale iv", {31'b0, inst_valid}, 32'd0);
    tick();
    chk("stale iv2", {31'b0, inst_valid}, 32'd0);
    chk("wait redir addr", imem_req_addr, 32'h8000_0100);

    // redirect beats inst_ready in HOLD
    mem_delay = 0; req_ready = 1; tick();
    req_ready = 0; tick();
    chk("hold pc 100", pc, 32'h8000_0100);
    redirect(32'h8000_0203); inst_ready = 1; tick();
    chk("hold redir iv", {31'b0, inst_valid}, 32'd0);
    chk("hold redir addr", imem_req_addr, 32'h8000_0200);
    inst_ready = 0;

    // redirect coincident with the request handshake
    req_ready = 1; redirect(32'h8000_1000); tick();
    req_ready = 0; tick();
    chk("coinc iv", {31'b0, inst_valid}, 32'd0);
    chk("coinc addr", imem_req_addr, 32'h8000_1000);

    // PC wrap
    redirect(32'hFFFF_FFFC); tick();
    req_ready = 1; tick();
    req_ready = 0; tick();
    chk("wrap pc", pc, 32'hFFFF_FFFC);
    inst_ready = 1; tick();
    chk("wrap addr", imem_req_addr, 32'h0000_0000);
    inst_ready = 0;

    // async reset while waiting, late response afterwards
    mem_delay = 2; req_ready = 1; tick();
    req_ready = 0; rst_n = 0; #1;
    model_reset();
    chk("ar req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("ar addr", imem_req_addr, RPC);
    chk("ar inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("ar inst", inst, NOP);
    chk("ar pc", pc, RPC);
    tick();
    rst_n = 1;
    tick(); tick();
    chk("late iv", {31'b0, inst_valid}, 32'd0);
    chk("late addr", imem_req_addr, RPC);

    // randomized traffic
    spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      req_ready  = ($urandom_range(0, 3) != 0);
      inst_ready = ($urandom_range(0, 2) != 0);
      mem_delay  = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0)
        redirect(($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + $urandom_range(0, 7)
                                             : $urandom);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifu.md
# ifu

Instruction fetch unit: owns the program counter, fetches one 32-bit instruction at a time from instruction memory over a valid/ready request plus response interface, and presents it with its PC to the decode stage. Sits directly upstream of decode and consumes PC redirects from execute. Single-issue, non-pipelined: at most one memory request is outstanding.

## Interface

- `RESET_PC`, default 32'h8000_0000: PC loaded at reset.
- `NOP_INST`, default 32'h0000_0013: value driven on `inst` when nothing is held (addi x0,x0,0).

Ports:

- `clk`  in  1  clock, all state updates on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts the request this cycle.
- `imem_req_addr`  out  32  fetch address, always word-aligned.
- `imem_resp_valid`  in  1  response data valid; always accepted, no backpressure.
- `imem_resp_data`  in  32  fetched instruction word.
- `redirect_valid`  in  1  execute requests a PC change; single-cycle pulse.
- `redirect_pc`  in  32  new PC; bits [1:0] ignored.
- `inst`  out  32  instruction to decode.
- `inst_valid`  out  1  `inst` and `pc` are valid.
- `inst_ready`  in  1  decode accepts the instruction this cycle.
- `pc`  out  32  address of `inst`.

## Operation

- States: BOOT, FETCH, WAIT, HOLD. Reset state is BOOT.
- Registers:
  - `pc_r`: fetch PC.
  - `inst_r`: held instruction.
  - `kill`: discard the pending response.
- Outputs:
  - `imem_req_valid = (state==FETCH)`.
  - `imem_req_addr = {pc_r[31:2],2'b00}`.
  - `pc = pc_r`.
  - `inst_valid = (state==HOLD)`.
  - `inst = inst_r` in HOLD, else NOP_INST.
- BOOT → FETCH unconditionally on the first edge after reset release.
- FETCH:
  - `imem_req_valid && imem_req_ready` → WAIT.
  - `kill <= redirect_valid`; this covers a redirect in the same cycle as the handshake, where the request for the old PC is in flight.
  - If `redirect_valid`, `pc_r <= {redirect_pc[31:2],2'b00}`, whether or not the request was accepted.
  - With no handshake, stay in FETCH and keep `imem_req_valid` high. The address may change only on a redirect.
- WAIT:
  - `redirect_valid` → `pc_r` loads the redirect target and `kill <= 1`.
  - On `imem_resp_valid`:
    - kill effective (registered `kill`, or `redirect_valid` this cycle) → discard the data, clear `kill`, go to FETCH.
    - otherwise → `inst_r <= imem_resp_data`, go to HOLD.
- HOLD:
  - `redirect_valid` has priority over `inst_ready`: drop the held instruction, load `pc_r` with the target, go to FETCH. Decode does not see a handshake that cycle, even with `inst_ready` high.
  - `inst_ready` without redirect → `pc_r <= pc_r + 4` (mod 2^32, wraps FFFF_FFFC→0000_0000), go to FETCH.
  - Otherwise hold. `inst` and `pc` stay stable while `inst_valid` is high.
- `imem_resp_valid` outside WAIT is ignored.
- `redirect_valid` in BOOT is ignored.
- Asserting `rst_n` low in any state returns immediately to BOOT with reset values. Any in-flight memory response is ignored because the block is not in WAIT.

## Timing

- Reset values:
  - `imem_req_valid` = 0
  - `imem_req_addr` = RESET_PC
  - `inst_valid` = 0
  - `inst` = NOP_INST
  - `pc` = RESET_PC
  - `kill` = 0
- First request is visible 1 cycle after reset release (BOOT cycle).
- Zero-wait memory (`imem_req_ready`=1, response 1 cycle after acceptance): request in cycle N, response in N+1, `inst_valid` in N+2. With `inst_ready`=1, the next request is in N+3, giving 1 instruction per 3 cycles.
- Redirect-to-request latency: 1 cycle from FETCH or HOLD. From WAIT, 1 cycle after the response arrives.
- All outputs are derived from registers only; there are no combinational paths from inputs to outputs.

## Test plan

- Reset then zero-wait memory returning 32'h00500093 at 8000_0000, `inst_ready`=1 → `imem_req_valid` first high 1 cycle after reset release, with addr 8000_0000. `inst_valid` rises 2 cycles later with `inst`=00500093 and `pc`=8000_0000. Next request addr is 8000_0004.
- Backpressure: `imem_req_ready` low for 3 cycles, then `inst_ready` low for 4 cycles → address stays 8000_0000 throughout the stall. `inst`/`pc` stay stable while `inst_valid` is high. Exactly one PC increment occurs.
- Redirect during WAIT to 8000_0100, response delayed 2 cycles → the stale response is discarded and `inst_valid` never rises for it. The next request addr is 8000_0100.
- Redirect in HOLD with `inst_ready`=1 in the same cycle, target 8000_0203 → `inst_valid` drops, `pc` does not become old+4, and the next request addr is 8000_0200.
- Redirect coincident with the FETCH handshake → the response for the old address is dropped and the next request is at the target.
- Wrap: redirect to FFFF_FFFC, accept the instruction → next request addr is 0000_0000. Pulse `rst_n` low while in WAIT → all outputs return to their reset values immediately, and a late `imem_resp_valid` is ignored.
